// File: rtl/systolic_mac_array.sv
// ROWS x COLS output-stationary systolic array; PEs do modulo MAC, saturating MAC or max-plus.
// Optional build macro: SYSTOLIC_TROPICAL_EN (max-plus for mode 2; otherwise mode 2 is MOD).
module systolic_mac_array #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int W    = 8,
   parameter int KW   = 8,
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [KW-1:0]      k_len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ROWS*W-1:0]  a_in,
   input  logic [COLS*W-1:0]  b_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COLS*W-1:0]  c_out,
   output logic [RW-1:0]      out_row,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

   localparam int FLUSH_LEN = ROWS + COLS - 1;
   localparam int FW        = $clog2(FLUSH_LEN + 1);

   state_t          state_q, state_d;
   logic [1:0]      mode_q;
   logic [KW-1:0]   klen_q, beat_q;
   logic [FW-1:0]   flush_q;
   logic [RW-1:0]   row_q;
   logic            clr, adv, inj_tag;

   function automatic logic [W-1:0] pe_op(input logic [1:0] m, input logic [W-1:0] acc,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] prod;
      logic [W:0]     sum;
      logic [W-1:0]   p;
      logic [W-1:0]   res;
      sum  = '0;
      p    = '0;
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (m)
         2'd1: begin
            p   = (|prod[2*W-1:W]) ? '1 : prod[W-1:0];
            sum = {1'b0, acc} + {1'b0, p};
            res = sum[W] ? '1 : sum[W-1:0];
         end
`ifdef SYSTOLIC_TROPICAL_EN
         2'd2: begin
            sum = {1'b0, a} + {1'b0, b};
            p   = sum[W] ? '1 : sum[W-1:0];
            res = (p > acc) ? p : acc;
         end
`endif
         default: res = acc + prod[W-1:0];
      endcase
      return res;
   endfunction

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: outputs get defaults before the case so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state_q != S_IDLE);
      clr       = 1'b0;
      adv       = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            clr     = 1'b1;
            state_d = (k_len == '0) ? S_FLUSH : S_FEED;
         end
         S_FEED: begin
            in_ready = 1'b1;
            adv      = in_valid;
            if (in_valid && beat_q == klen_q - KW'(1)) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            adv = 1'b1;
            if (flush_q == FW'(FLUSH_LEN - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && row_q == RW'(ROWS - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q  <= '0;
         klen_q  <= '0;
         beat_q  <= '0;
         flush_q <= '0;
         row_q   <= '0;
      end else begin
         if (clr) begin
            mode_q  <= mode;
            klen_q  <= k_len;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
         end
         if (state_q == S_FEED && in_valid) beat_q <= beat_q + KW'(1);
         if (state_q == S_FLUSH) flush_q <= flush_q + FW'(1);
         if (out_valid && out_ready) row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      end
   end

   // Accepted beats enter tagged valid; flush cycles push zero-data bubbles.
   assign inj_tag = (state_q == S_FEED);

   logic [W-1:0] a_edge [ROWS];
   logic         ta_edge [ROWS];
   logic [W-1:0] b_edge [COLS];
   logic         tb_edge [COLS];

   for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
      logic [W-1:0] a_src;
      assign a_src = inj_tag ? a_in[r*W +: W] : '0;
      if (r == 0) begin : g_direct
         assign a_edge[r]  = a_src;
         assign ta_edge[r] = inj_tag;
      end else begin : g_delay
         logic [W-1:0] d_q [r];
         logic         t_q [r];
         // NOTE: pipeline regs are reset too: their valid tags must start as bubbles.
         always_ff @(posedge clk) begin
            if (reset || clr) begin
               for (int i = 0; i < r; i++) begin
                  d_q[i] <= '0;
                  t_q[i] <= 1'b0;
               end
            end else if (adv) begin
               d_q[0] <= a_src;
               t_q[0] <= inj_tag;
               for (int i = 1; i < r; i++) begin
                  d_q[i] <= d_q[i-1];
                  t_q[i] <= t_q[i-1];
               end
            end
         end
         assign a_edge[r]  = d_q[r-1];
         assign ta_edge[r] = t_q[r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_b_skew
      logic [W-1:0] b_src;
      assign b_src = inj_tag ? b_in[c*W +: W] : '0;
      if (c == 0) begin : g_direct
         assign b_edge[c]  = b_src;
         assign tb_edge[c] = inj_tag;
      end else begin : g_delay
         logic [W-1:0] d_q [c];
         logic         t_q [c];
         always_ff @(posedge clk) begin
            if (reset || clr) begin
               for (int i = 0; i < c; i++) begin
                  d_q[i] <= '0;
                  t_q[i] <= 1'b0;
               end
            end else if (adv) begin
               d_q[0] <= b_src;
               t_q[0] <= inj_tag;
               for (int i = 1; i < c; i++) begin
                  d_q[i] <= d_q[i-1];
                  t_q[i] <= t_q[i-1];
               end
            end
         end
         assign b_edge[c]  = d_q[c-1];
         assign tb_edge[c] = t_q[c-1];
      end
   end

   logic [W-1:0] a_q [ROWS][COLS];
   logic [W-1:0] b_q [ROWS][COLS];
   logic [W-1:0] acc_q [ROWS][COLS];
   logic         ta_q [ROWS][COLS];
   logic         tb_q [ROWS][COLS];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_pe
         logic [W-1:0] a_l, b_t, a_r, b_r, acc_r;
         logic         ta_l, tb_t, ta_r, tb_r;
         if (c == 0) begin : g_l_edge
            assign a_l  = a_edge[r];
            assign ta_l = ta_edge[r];
         end else begin : g_l_pe
            assign a_l  = a_q[r][c-1];
            assign ta_l = ta_q[r][c-1];
         end
         if (r == 0) begin : g_t_edge
            assign b_t  = b_edge[c];
            assign tb_t = tb_edge[c];
         end else begin : g_t_pe
            assign b_t  = b_q[r-1][c];
            assign tb_t = tb_q[r-1][c];
         end
         always_ff @(posedge clk) begin
            if (reset) begin
               a_r   <= '0;
               b_r   <= '0;
               ta_r  <= 1'b0;
               tb_r  <= 1'b0;
               acc_r <= '0;
            end else if (clr) begin
               ta_r  <= 1'b0;
               tb_r  <= 1'b0;
               acc_r <= '0;
            end else if (adv) begin
               a_r  <= a_l;
               b_r  <= b_t;
               ta_r <= ta_l;
               tb_r <= tb_t;
               if (ta_l && tb_t) acc_r <= pe_op(mode_q, acc_r, a_l, b_t);
            end
         end
         assign a_q[r][c]   = a_r;
         assign b_q[r][c]   = b_r;
         assign ta_q[r][c]  = ta_r;
         assign tb_q[r][c]  = tb_r;
         assign acc_q[r][c] = acc_r;
      end
   end

   always_comb begin
      c_out = '0;
      if (out_valid)
         for (int c = 0; c < COLS; c++) c_out[c*W +: W] = acc_q[row_q][c];
   end

   assign out_row = row_q;

endmodule
